// File: rtl/rvc_fetch_aligner_pkg.sv
// Shared constants and helpers for the RVC fetch aligner.
package rvc_fetch_aligner_pkg;

    localparam logic [1:0] INST_QUAD_32B  = 2'b11;
    localparam int         HALFWORD_BYTES = 2;

    // A halfword starts a compressed instruction unless its low quadrant bits are 11.
    function automatic logic hw_is_rvc(input logic [1:0] quad);
        return (quad != INST_QUAD_32B);
    endfunction

endpackage

// File: rtl/rvc_fetch_aligner.sv
// Splits aligned 32-bit fetch words into a mixed 16/32-bit instruction stream,
// joining 32-bit instructions that straddle two fetch words.
module rvc_fetch_aligner
    import rvc_fetch_aligner_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [31:0]     in_word,
    input  logic [PC_W-1:0] in_pc,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [31:0]     out_inst,
    output logic [PC_W-1:0] out_pc,
    output logic            out_rvc,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic            flush,
    input  logic [PC_W-1:0] flush_pc
);

    logic [31:0]     word_r;
    logic [PC_W-1:0] buf_pc_r;
    logic            buf_vld_r;
    logic            ptr_r;
    logic [15:0]     hold_r;
    logic [PC_W-1:0] hold_pc_r;
    logic            hold_vld_r;
    logic            skip_r;

    logic [15:0]     hw_s;
    logic [PC_W-1:0] half_pc_s;
    logic [31:0]     sel_inst_s;
    logic [PC_W-1:0] sel_pc_s;
    logic            sel_rvc_s;
    logic            sel_vld_s;
    logic            joined_s;
    logic            free_s;
    logic            straddle_s;
    logic            hs_s;
    logic            accept_s;
    logic            flush_pc_unused_s;

    assign hw_s      = ptr_r ? word_r[31:16] : word_r[15:0];
    assign half_pc_s = buf_pc_r + (ptr_r ? PC_W'(HALFWORD_BYTES) : {PC_W{1'b0}});
    assign flush_pc_unused_s = ^{flush_pc[PC_W-1:2], flush_pc[0]};

    // Select the instruction to present from the current buffer/hold state.
    always_comb begin
        sel_inst_s = 32'h0000_0000;
        sel_pc_s   = {PC_W{1'b0}};
        sel_rvc_s  = 1'b0;
        sel_vld_s  = 1'b0;
        joined_s   = 1'b0;
        free_s     = 1'b0;
        straddle_s = 1'b0;
        if (hold_vld_r && buf_vld_r) begin
            sel_inst_s = {word_r[15:0], hold_r};
            sel_pc_s   = hold_pc_r;
            sel_vld_s  = 1'b1;
            joined_s   = 1'b1;
        end else if (buf_vld_r) begin
            if (hw_is_rvc(hw_s[1:0])) begin
                sel_inst_s = {16'h0000, hw_s};
                sel_pc_s   = half_pc_s;
                sel_rvc_s  = 1'b1;
                sel_vld_s  = 1'b1;
                free_s     = ptr_r && out_ready && !flush;
            end else if (!ptr_r) begin
                sel_inst_s = word_r;
                sel_pc_s   = buf_pc_r;
                sel_vld_s  = 1'b1;
                free_s     = out_ready && !flush;
            end else begin
                // Upper half begins a 32-bit instruction: park it and spend one bubble.
                straddle_s = !flush;
                free_s     = !flush;
            end
        end else begin
            sel_vld_s = 1'b0;
        end
    end

    assign hs_s      = sel_vld_s && out_ready && !flush;
    assign out_valid = sel_vld_s && !flush;
    assign out_inst  = sel_inst_s;
    assign out_pc    = sel_pc_s;
    assign out_rvc   = sel_rvc_s;
    assign in_ready  = !flush && (!buf_vld_r || free_s);
    assign accept_s  = in_valid && in_ready;

    // Buffer, hold and skip state update.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_r     <= 32'h0000_0000;
            buf_pc_r   <= {PC_W{1'b0}};
            buf_vld_r  <= 1'b0;
            ptr_r      <= 1'b0;
            hold_r     <= 16'h0000;
            hold_pc_r  <= {PC_W{1'b0}};
            hold_vld_r <= 1'b0;
            skip_r     <= 1'b0;
        end else if (flush) begin
            buf_vld_r  <= 1'b0;
            hold_vld_r <= 1'b0;
            ptr_r      <= 1'b0;
            skip_r     <= flush_pc[1];
        end else begin
            if (joined_s && hs_s) begin
                hold_vld_r <= 1'b0;
                ptr_r      <= 1'b1;
            end else if (sel_rvc_s && hs_s) begin
                ptr_r <= ~ptr_r;
            end else if (straddle_s) begin
                hold_r     <= hw_s;
                hold_pc_r  <= half_pc_s;
                hold_vld_r <= 1'b1;
            end else begin
                ptr_r <= ptr_r;
            end
            if (free_s) begin
                buf_vld_r <= 1'b0;
            end else begin
                buf_vld_r <= buf_vld_r;
            end
            if (accept_s) begin
                word_r    <= in_word;
                buf_pc_r  <= in_pc;
                buf_vld_r <= 1'b1;
                ptr_r     <= skip_r;
                skip_r    <= 1'b0;
            end else begin
                skip_r <= skip_r;
            end
        end
    end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Directed self-checking bench for rvc_fetch_aligner.
module tb_rvc_fetch_aligner;

    localparam int PC_W = 64;

    logic            clock;
    logic            reset_n;
    logic [31:0]     in_word;
    logic [PC_W-1:0] in_pc;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     out_inst;
    logic [PC_W-1:0] out_pc;
    logic            out_rvc;
    logic            out_valid;
    logic            out_ready;
    logic            flush;
    logic [PC_W-1:0] flush_pc;

    int n_checks = 0;
    int n_fail   = 0;

    rvc_fetch_aligner #(.PC_W(PC_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_word   (in_word),
        .in_pc     (in_pc),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .out_rvc   (out_rvc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .flush_pc  (flush_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] inst,
                              input logic [63:0] pc, input logic rvc);
        check_eq({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check_eq({tag, "_inst"}, {32'd0, out_inst}, {32'd0, inst});
        check_eq({tag, "_pc"}, out_pc, pc);
        check_eq({tag, "_rvc"}, {63'd0, out_rvc}, {63'd0, rvc});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_word(input logic [31:0] w, input logic [63:0] pc);
        in_word  = w;
        in_pc    = pc;
        in_valid = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_word   = 32'h0;
        in_pc     = 64'h0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        flush_pc  = 64'h0;
        #12;
        check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_inst", {32'd0, out_inst}, 64'd0);
        check_eq("rst_pc", out_pc, 64'd0);
        check_eq("rst_rvc", {63'd0, out_rvc}, 64'd0);
        check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        reset_n = 1'b1;

        // Case 1: single 32-bit word.
        tick();
        drive_word(32'h0000_0013, 64'h8000_0000);
        #1 check_eq("c1_rdy0", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        #1 expect_out("c1", 32'h0000_0013, 64'h8000_0000, 1'b0);
        check_eq("c1_rdy1", {63'd0, in_ready}, 64'd1);
        tick();
        check_eq("c1_empty", {63'd0, out_valid}, 64'd0);

        // Case 2: two compressed halves.
        drive_word(32'h4505_0505, 64'h8000_0000);
        tick();
        in_valid = 1'b0;
        #1 expect_out("c2a", 32'h0000_0505, 64'h8000_0000, 1'b1);
        check_eq("c2a_rdy", {63'd0, in_ready}, 64'd0);
        tick();
        expect_out("c2b", 32'h0000_4505, 64'h8000_0002, 1'b1);
        check_eq("c2b_rdy", {63'd0, in_ready}, 64'd1);
        tick();
        check_eq("c2_empty", {63'd0, out_valid}, 64'd0);

        // Case 3: straddling 32-bit instruction.
        drive_word(32'h0513_4505, 64'h8000_0000);
        tick();
        in_valid = 1'b0;
        #1 expect_out("c3a", 32'h0000_4505, 64'h8000_0000, 1'b1);
        tick();
        check_eq("c3_bubble", {63'd0, out_valid}, 64'd0);
        check_eq("c3_bub_rdy", {63'd0, in_ready}, 64'd1);
        drive_word(32'h4505_0000, 64'h8000_0004);
        tick();
        in_valid = 1'b0;
        #1 expect_out("c3b", 32'h0000_0513, 64'h8000_0002, 1'b0);
        tick();
        expect_out("c3c", 32'h0000_4505, 64'h8000_0006, 1'b1);
        tick();
        check_eq("c3_empty", {63'd0, out_valid}, 64'd0);

        // Case 4: back-pressure holds outputs stable.
        out_ready = 1'b0;
        drive_word(32'h4505_0505, 64'h8000_0000);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 expect_out("c4_stall", 32'h0000_0505, 64'h8000_0000, 1'b1);
            check_eq("c4_stall_rdy", {63'd0, in_ready}, 64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1 expect_out("c4a", 32'h0000_0505, 64'h8000_0000, 1'b1);
        tick();
        expect_out("c4b", 32'h0000_4505, 64'h8000_0002, 1'b1);
        tick();
        check_eq("c4_empty", {63'd0, out_valid}, 64'd0);

        // Case 5: flush while a straddling half is held.
        drive_word(32'h0513_4505, 64'h8000_0000);
        tick();
        in_valid = 1'b0;
        #1 expect_out("c5a", 32'h0000_4505, 64'h8000_0000, 1'b1);
        tick();
        tick();
        check_eq("c5_hold_valid", {63'd0, out_valid}, 64'd0);
        check_eq("c5_hold_rdy", {63'd0, in_ready}, 64'd1);
        flush    = 1'b1;
        flush_pc = 64'h8000_0102;
        drive_word(32'hFFFF_FFFF, 64'h8000_0200);
        #1 check_eq("c5_fl_rdy", {63'd0, in_ready}, 64'd0);
        check_eq("c5_fl_valid", {63'd0, out_valid}, 64'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1 check_eq("c5_post_valid", {63'd0, out_valid}, 64'd0);
        drive_word(32'h4505_0505, 64'h8000_0100);
        #1 check_eq("c5_post_rdy", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        #1 expect_out("c5b", 32'h0000_4505, 64'h8000_0102, 1'b1);
        tick();
        check_eq("c5_single", {63'd0, out_valid}, 64'd0);

        // Case 6: reset during a straddle.
        drive_word(32'h0513_4505, 64'h8000_0000);
        tick();
        in_valid = 1'b0;
        #1 expect_out("c6a", 32'h0000_4505, 64'h8000_0000, 1'b1);
        tick();
        drive_word(32'h4505_0000, 64'h8000_0004);
        tick();
        in_valid = 1'b0;
        #1 expect_out("c6_joined", 32'h0000_0513, 64'h8000_0002, 1'b0);
        reset_n = 1'b0;
        #1 check_eq("c6_rst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("c6_rst_rdy", {63'd0, in_ready}, 64'd1);
        tick();
        reset_n = 1'b1;
        drive_word(32'h0000_0013, 64'h8000_0000);
        tick();
        in_valid = 1'b0;
        #1 expect_out("c6b", 32'h0000_0013, 64'h8000_0000, 1'b0);
        tick();
        check_eq("c6_empty", {63'd0, out_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
